lsu_cache_port: RTL and testbench



---
 rtl/lsu_cache_port.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_cache_port.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_cache_port.sv
// Load/store sequencer in front of the cache. It takes one CPU request at a time,
// rejects misaligned or illegal sizes, and drives the cache strobes using the
// cache_rdy fall/rise handshake. It answers with a single-cycle response and keeps
// saturating access and stall counters.
module lsu_cache_port #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [31:0]      rsp_rdata,
  output logic             ren,
  output logic             wen,
  output logic [31:0]      addr,
  output logic [31:0]      din,
  output logic [4:0]       loadcntrl,
  output logic [2:0]       storecntrl,
  input  logic [31:0]      dout,
  input  logic             cache_rdy,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWaitRdy, StReq, StBusy, StResp, StErr} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       addr_q, addr_d, din_q, din_d, rdata_q, rdata_d;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic [4:0]        lc_q, lc_d, lc_dec;
  logic [2:0]        sc_q, sc_d, sc_dec;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]  acc_q, acc_d, stall_q, stall_d;
  logic              misaligned, in_access, tmo_hit, acc_inc;

  assign in_access = (state_q == StReq) || (state_q == StBusy);
  // Fires on the TIMEOUT-th cycle spent in REQ+BUSY.
  assign tmo_hit   = in_access && (tmo_q == TmoW'(TIMEOUT - 1));

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Decode the latched access type into the cache's one-hot control buses.
  always_comb begin
    lc_dec = '0;
    sc_dec = '0;
    unique case (size_q)
      2'b00: begin
        lc_dec = uns_q ? 5'b01000 : 5'b00001;
        sc_dec = 3'b001;
      end
      2'b01: begin
        lc_dec = uns_q ? 5'b10000 : 5'b00010;
        sc_dec = 3'b010;
      end
      2'b10: begin
        lc_dec = 5'b00100;
        sc_dec = 3'b100;
      end
      default: begin
        lc_dec = '0;
        sc_dec = '0;
      end
    endcase
  end

  // Next-state, strobe and counter logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    lc_d    = lc_q;
    sc_d    = sc_q;
    tmo_d   = tmo_q;
    acc_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          size_d  = req_size;
          addr_d  = req_addr;
          din_d   = req_wdata;
          state_d = misaligned ? StErr : StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (cache_rdy) begin
          state_d = StReq;
          tmo_d   = '0;
          ren_d   = ~we_q;
          wen_d   = we_q;
          lc_d    = we_q ? 5'b0 : lc_dec;
          sc_d    = we_q ? sc_dec : 3'b0;
        end
      end
      StReq, StBusy: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_hit) begin
          state_d = StErr;
          acc_inc = 1'b1;
        end else if (state_q == StReq && !cache_rdy) begin
          state_d = StBusy;
        end else if (state_q == StBusy && cache_rdy) begin
          state_d = StResp;
          rdata_d = dout;
        end
        // The strobe is dropped on the same edge that leaves REQ.
        if (state_d != StReq) begin
          ren_d = 1'b0;
          wen_d = 1'b0;
          lc_d  = '0;
          sc_d  = '0;
        end
      end
      StResp: begin
        acc_inc = 1'b1;
        state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    acc_d   = (acc_inc && acc_q != '1) ? acc_q + 1'b1 : acc_q;
    stall_d = (in_access && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      lc_q    <= '0;
      sc_q    <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      lc_q    <= lc_d;
      sc_q    <= sc_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp) || (state_q == StErr);
  assign rsp_err    = (state_q == StErr);
  assign rsp_rdata  = (state_q == StResp && !we_q) ? rdata_q : 32'h0;
  assign ren        = ren_q;
  assign wen        = wen_q;
  assign addr       = addr_q;
  assign din        = din_q;
  assign loadcntrl  = lc_q;
  assign storecntrl = sc_q;
  assign access_cnt = acc_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_lsu_cache_port.sv
// Self-checking bench for lsu_cache_port: a behavioural cache answers the strobes,
// expected responses are queued at issue and checked when rsp_valid pulses.
module tb_lsu_cache_port;

  localparam int Lat = 3;  // cache busy cycles after cache_rdy falls
  localparam int Tmo = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ren, wen;
  logic [31:0] addr, din, dout;
  logic [4:0]  loadcntrl;
  logic [2:0]  storecntrl;
  logic        cache_rdy;
  logic [31:0] access_cnt, stall_cnt;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        sb_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, n_rsp = 0, rsp_cyc = 0, strobe_cnt = 0, strobe_first = -1;
  int          exp_acc = 0, exp_stall = 0;
  logic [4:0]  exp_lc = '0;
  logic [2:0]  exp_sc = '0;
  logic [31:0] exp_din = '0, exp_addr = '0;
  logic        stuck = 1'b0;

  always #5 clk = ~clk;

  lsu_cache_port #(
    .TIMEOUT (Tmo),
    .CNT_W   (32)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .ren          (ren),
    .wen          (wen),
    .addr         (addr),
    .din          (din),
    .loadcntrl    (loadcntrl),
    .storecntrl   (storecntrl),
    .dout         (dout),
    .cache_rdy    (cache_rdy),
    .access_cnt   (access_cnt),
    .stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural cache ----------------
  logic [31:0] mem [0:2047];
  int          busy_cnt;
  logic [31:0] m_addr, m_din;
  logic [4:0]  m_lc;
  logic [2:0]  m_sc;
  logic        m_we;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] o,
                                           input logic [4:0] lc);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*o +: 8];
    h = w[16*o[1] +: 16];
    case (lc)
      5'b00001: return {{24{b[7]}}, b};
      5'b01000: return {24'h0, b};
      5'b00010: return {{16{h[15]}}, h};
      5'b10000: return {16'h0, h};
      default:  return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] o, input logic [2:0] sc);
    logic [31:0] r;
    r = w;
    case (sc)
      3'b001:  r[8*o +: 8] = d[7:0];
      3'b010:  r[16*o[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_rdy <= 1'b1;
      busy_cnt  <= 0;
      dout      <= '0;
    end else if (busy_cnt == 0) begin
      if (cache_rdy && (ren || wen)) begin
        cache_rdy <= 1'b0;
        busy_cnt  <= stuck ? -1 : Lat;
        m_addr    <= addr;
        m_din     <= din;
        m_lc      <= loadcntrl;
        m_sc      <= storecntrl;
        m_we      <= wen;
      end
    end else if (busy_cnt < 0) begin
      if (!stuck) begin
        cache_rdy <= 1'b1;
        busy_cnt  <= 0;
      end
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      cache_rdy <= 1'b1;
      busy_cnt  <= 0;
      if (m_we) mem[m_addr[12:2]] <= merge(mem[m_addr[12:2]], m_din, m_addr[1:0], m_sc);
      else      dout <= load_ext(mem[m_addr[12:2]], m_addr[1:0], m_lc);
    end
  end

  // ---------------- cycle counter and monitor ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (rst) begin
      if (ren || wen) begin
        strobe_cnt++;
        if (strobe_first < 0) strobe_first = cyc;
        check("strb_addr", addr, exp_addr);
        if (ren) begin
          check("loadcntrl", loadcntrl, exp_lc);
          check("sc_unused", storecntrl, 0);
        end
        if (wen) begin
          check("storecntrl", storecntrl, exp_sc);
          check("din", din, exp_din);
          check("lc_unused", loadcntrl, 0);
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        rsp_cyc = cyc;
        check("rsp_strb", {ren, wen}, 0);
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rsp_err", rsp_err, e.err);
          check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready", req_ready, 1);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, output int xf);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    xf           = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ready_low", req_ready, 0);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic err,
                        input logic [31:0] rdata, input logic [4:0] lc, input logic [2:0] sc,
                        input int lat, input int d_acc, input int d_stall);
    int   k, n0, s0, xf;
    rsp_t e;
    wait_ready();
    exp_lc       = lc;
    exp_sc       = sc;
    exp_din      = wd;
    exp_addr     = a;
    strobe_first = -1;
    s0           = strobe_cnt;
    n0           = n_rsp;
    e.err        = err;
    e.rdata      = rdata;
    sb_q.push_back(e);
    drive(we, sz, uns, a, wd, xf);
    k = 0;
    while (n_rsp == n0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rsp_count", n_rsp - n0, 1);
    check("rsp_latency", rsp_cyc - xf, lat);
    if (err && d_acc == 0) check("no_strobe", strobe_cnt - s0, 0);
    else                   check("strobe_latency", strobe_first - xf, 2);
    @(posedge clk);
    #1;
    exp_acc   += d_acc;
    exp_stall += d_stall;
    check("access_cnt", access_cnt, exp_acc);
    check("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_strb"}, {ren, wen, loadcntrl, storecntrl}, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_din"}, din, 0);
    check({tag, "_rsp"}, {rsp_valid, rsp_err}, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_acc"}, access_cnt, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    int k, n0, xf;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Word store then load, with a miss modelled by the cache.
    do_req(1, 2'b10, 0, 32'h0, 32'h1122_3344, 0, 32'h0, 5'b0, 3'b100, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b10, 0, 32'h0, 32'h0, 0, 32'h1122_3344, 5'b00100, 3'b0, Lat + 4, 1, Lat + 2);
    do_req(1, 2'b10, 0, 32'h1000, 32'hdead_beef, 0, 32'h0, 5'b0, 3'b100, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b10, 0, 32'h1000, 32'h0, 0, 32'hdead_beef, 5'b00100, 3'b0, Lat + 4, 1, Lat + 2);

    // Alignment and illegal-size errors: one cycle, no strobe, counters unchanged.
    do_req(0, 2'b01, 0, 32'h3, 32'h0, 1, 32'h0, 5'b0, 3'b0, 1, 0, 0);
    do_req(0, 2'b10, 0, 32'h2, 32'h0, 1, 32'h0, 5'b0, 3'b0, 1, 0, 0);
    do_req(1, 2'b11, 0, 32'h0, 32'h5, 1, 32'h0, 5'b0, 3'b0, 1, 0, 0);

    // Sub-word accesses.
    do_req(1, 2'b10, 0, 32'h4, 32'h1234_80ab, 0, 32'h0, 5'b0, 3'b100, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b00, 1, 32'h5, 32'h0, 0, 32'h0000_0080, 5'b01000, 3'b0, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b00, 0, 32'h5, 32'h0, 0, 32'hffff_ff80, 5'b00001, 3'b0, Lat + 4, 1, Lat + 2);
    do_req(1, 2'b01, 0, 32'h6, 32'h0000_cafe, 0, 32'h0, 5'b0, 3'b010, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b01, 1, 32'h6, 32'h0, 0, 32'h0000_cafe, 5'b10000, 3'b0, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b01, 0, 32'h6, 32'h0, 0, 32'hffff_cafe, 5'b00010, 3'b0, Lat + 4, 1, Lat + 2);
    do_req(1, 2'b00, 0, 32'h7, 32'h0000_0055, 0, 32'h0, 5'b0, 3'b001, Lat + 4, 1, Lat + 2);
    do_req(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h55fe_80ab, 5'b00100, 3'b0, Lat + 4, 1, Lat + 2);

    // Cache never comes back: timeout after Tmo cycles in REQ+BUSY.
    stuck = 1'b1;
    do_req(0, 2'b10, 0, 32'h0, 32'h0, 1, 32'h0, 5'b00100, 3'b0, Tmo + 2, 1, Tmo);
    stuck = 1'b0;
    do_req(0, 2'b10, 0, 32'h1000, 32'h0, 0, 32'hdead_beef, 5'b00100, 3'b0, Lat + 4, 1, Lat + 2);

    // Reset while the cache is busy: everything clears, no response appears.
    wait_ready();
    exp_lc       = 5'b00100;
    exp_sc       = 3'b0;
    exp_addr     = 32'h1000;
    exp_din      = 32'h0;
    strobe_first = -1;
    drive(0, 2'b10, 0, 32'h1000, 32'h0, xf);
    k = 0;
    while ((strobe_first < 0 || ren) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reached_busy", k < 50, 1);
    n0 = n_rsp;
    #2 rst = 1'b0;
    #1 check_reset("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("no_rsp_after_reset", n_rsp - n0, 0);
    check("ready_after_mid_reset", req_ready, 1);
    exp_acc   = 0;
    exp_stall = 0;
    do_req(0, 2'b10, 0, 32'h1000, 32'h0, 0, 32'hdead_beef, 5'b00100, 3'b0, Lat + 4, 1, Lat + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
